// File: rtl/command_arbiter_rr.sv
// Credit-gated round-robin command arbiter: one registered grant per cycle while PSL credits
// remain, with tag and issue counters and a sticky credit-overflow flag.
module command_arbiter_rr #(
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned CREDIT_WIDTH   = 8,
   parameter int unsigned TAG_WIDTH      = 8,
   localparam int unsigned SRC_WIDTH     = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
   input  logic                      clock,
   input  logic                      rstn,
   input  logic                      enabled_in,
   input  logic                      credit_init_valid,
   input  logic [CREDIT_WIDTH-1:0]   credit_init,
   input  logic                      credit_return,
   input  logic [NUM_REQUESTERS-1:0] req_valid,
   output logic [NUM_REQUESTERS-1:0] grant_out,
   output logic                      cmd_valid_out,
   output logic [SRC_WIDTH-1:0]      cmd_src_out,
   output logic [TAG_WIDTH-1:0]      cmd_tag_out,
   output logic [CREDIT_WIDTH-1:0]   credits_out,
   output logic [31:0]               issued_count_out,
   output logic                      credit_error_out
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   localparam logic [SRC_WIDTH-1:0] LastInit = SRC_WIDTH'(NUM_REQUESTERS - 1);

   state_e                    state_q, state_d;
   logic [NUM_REQUESTERS-1:0] req_q, req_d;
   logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
   logic                      cmd_valid_q, cmd_valid_d;
   logic [SRC_WIDTH-1:0]      cmd_src_q, cmd_src_d;
   logic [TAG_WIDTH-1:0]      cmd_tag_q, cmd_tag_d;
   logic [TAG_WIDTH-1:0]      tag_q, tag_d;
   logic [CREDIT_WIDTH-1:0]   credits_q, credits_d;
   logic [CREDIT_WIDTH-1:0]   credit_max_q, credit_max_d;
   logic [SRC_WIDTH-1:0]      last_q, last_d;
   logic [31:0]               issued_q, issued_d;
   logic                      error_q, error_d;

   logic [NUM_REQUESTERS-1:0] eligible;
   logic                      pick_found;
   logic [SRC_WIDTH-1:0]      pick_idx;
   logic                      issue;

   function automatic logic [SRC_WIDTH-1:0] rr_index(input logic [SRC_WIDTH-1:0] last,
                                                     input int unsigned offset);
      return SRC_WIDTH'((32'(last) + 32'd1 + offset) % NUM_REQUESTERS);
   endfunction

   // The source granted last edge may still show a stale captured request; mask it once.
   assign eligible = req_q & ~grant_q;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         if (!pick_found && eligible[rr_index(last_q, i)]) begin
            pick_found = 1'b1;
            pick_idx   = rr_index(last_q, i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      req_d        = enabled_in ? req_valid : '0;
      grant_d      = '0;
      cmd_valid_d  = 1'b0;
      cmd_src_d    = cmd_src_q;
      cmd_tag_d    = cmd_tag_q;
      tag_d        = tag_q;
      credits_d    = credits_q;
      credit_max_d = credit_max_q;
      last_d       = last_q;
      issued_d     = issued_q;
      error_d      = error_q;
      issue        = 1'b0;

      unique case (state_q)
         StIdle: state_d = StLoad;
         StLoad: begin
            if (credit_init_valid) begin
               credits_d    = credit_init;
               credit_max_d = credit_init;
               if (credit_init != '0) state_d = StRun;
            end
         end
         StRun: begin
            issue = pick_found && (credits_q != '0);
            if (issue) begin
               grant_d[pick_idx] = 1'b1;
               cmd_valid_d       = 1'b1;
               cmd_src_d         = pick_idx;
               cmd_tag_d         = tag_q;
               tag_d             = tag_q + TAG_WIDTH'(1);
               last_d            = pick_idx;
               issued_d          = issued_q + 32'd1;
            end
            if (issue && !credit_return) begin
               credits_d = credits_q - CREDIT_WIDTH'(1);
            end else if (!issue && credit_return) begin
               if (credits_q == credit_max_q) error_d = 1'b1;
               else                           credits_d = credits_q + CREDIT_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Dropping enable is a synchronous soft reset with the same values as rstn.
      if (!enabled_in) begin
         state_d      = StIdle;
         grant_d      = '0;
         cmd_valid_d  = 1'b0;
         cmd_src_d    = '0;
         cmd_tag_d    = '0;
         tag_d        = '0;
         credits_d    = '0;
         credit_max_d = '0;
         last_d       = LastInit;
         issued_d     = '0;
         error_d      = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         req_q        <= '0;
         grant_q      <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_src_q    <= '0;
         cmd_tag_q    <= '0;
         tag_q        <= '0;
         credits_q    <= '0;
         credit_max_q <= '0;
         last_q       <= LastInit;
         issued_q     <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         grant_q      <= grant_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_src_q    <= cmd_src_d;
         cmd_tag_q    <= cmd_tag_d;
         tag_q        <= tag_d;
         credits_q    <= credits_d;
         credit_max_q <= credit_max_d;
         last_q       <= last_d;
         issued_q     <= issued_d;
         error_q      <= error_d;
      end
   end

   assign grant_out        = grant_q;
   assign cmd_valid_out    = cmd_valid_q;
   assign cmd_src_out      = cmd_src_q;
   assign cmd_tag_out      = cmd_tag_q;
   assign credits_out      = credits_q;
   assign issued_count_out = issued_q;
   assign credit_error_out = error_q;

endmodule

// File: tb/tb_command_arbiter_rr.sv
// Bench for command_arbiter_rr: directed scenarios plus random traffic, checked by a
// scoreboard fed from a behavioural model of the arbitration and credit rules.
module tb_command_arbiter_rr;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int TW = 8;

   logic          clock = 1'b0;
   logic          rstn = 1'b0;
   logic          enabled_in = 1'b0;
   logic          credit_init_valid = 1'b0;
   logic [CW-1:0] credit_init = '0;
   logic          credit_return = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  grant_out;
   logic          cmd_valid_out;
   logic [1:0]    cmd_src_out;
   logic [TW-1:0] cmd_tag_out;
   logic [CW-1:0] credits_out;
   logic [31:0]   issued_count_out;
   logic          credit_error_out;

   command_arbiter_rr #(
      .NUM_REQUESTERS(N),
      .CREDIT_WIDTH  (CW),
      .TAG_WIDTH     (TW)
   ) dut (
      .clock            (clock),
      .rstn             (rstn),
      .enabled_in       (enabled_in),
      .credit_init_valid(credit_init_valid),
      .credit_init      (credit_init),
      .credit_return    (credit_return),
      .req_valid        (req_valid),
      .grant_out        (grant_out),
      .cmd_valid_out    (cmd_valid_out),
      .cmd_src_out      (cmd_src_out),
      .cmd_tag_out      (cmd_tag_out),
      .credits_out      (credits_out),
      .issued_count_out (issued_count_out),
      .credit_error_out (credit_error_out)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 waiting for credits, 2 issuing.
   typedef struct {int src; int tag;} exp_t;
   exp_t         sb[$];
   int           m_phase, m_credits, m_max, m_last, m_tag, m_prev_grant, m_src, m_out_tag;
   int           m_pick, m_cand;
   int unsigned  m_count;
   bit           m_err, m_issued;
   bit [N-1:0]   m_req_prev;

   function automatic void m_reset();
      m_phase = 0; m_credits = 0; m_max = 0; m_last = N - 1; m_tag = 0;
      m_prev_grant = -1; m_src = 0; m_out_tag = 0; m_count = 0; m_err = 0;
      m_req_prev = '0;
      sb.delete();
   endfunction

   always @(posedge clock or negedge rstn) begin
      if (!rstn || !enabled_in) begin
         m_reset();
      end else begin
         m_issued = 0;
         m_pick   = -1;
         case (m_phase)
            0: m_phase = 1;
            1: if (credit_init_valid) begin
                  m_credits = int'(credit_init);
                  m_max     = int'(credit_init);
                  if (credit_init != 0) m_phase = 2;
               end
            default: begin
               if (m_credits > 0) begin
                  for (int i = 0; i < N; i++) begin
                     m_cand = (m_last + 1 + i) % N;
                     if (m_pick < 0 && m_req_prev[m_cand] && m_cand != m_prev_grant) m_pick = m_cand;
                  end
               end
               m_issued = (m_pick >= 0);
               if (m_issued) begin
                  sb.push_back('{m_pick, m_tag});
                  m_src     = m_pick;
                  m_out_tag = m_tag;
                  m_tag     = (m_tag + 1) % (1 << TW);
                  m_count++;
                  m_last    = m_pick;
               end
               if (m_issued && !credit_return) m_credits--;
               else if (!m_issued && credit_return) begin
                  if (m_credits == m_max) m_err = 1;
                  else m_credits++;
               end
            end
         endcase
         m_prev_grant = m_issued ? m_pick : -1;
         m_req_prev   = req_valid;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT issues, and tracks visible state.
   always @(negedge clock) begin
      exp_t e;
      if (rstn) begin
         if (cmd_valid_out) begin
            if (sb.size() == 0) check("spurious_issue", cmd_valid_out, 0);
            else begin
               e = sb.pop_front();
               check("grant_onehot", grant_out, 1 << e.src);
               check("cmd_src", cmd_src_out, e.src);
               check("cmd_tag", cmd_tag_out, e.tag);
            end
         end else begin
            if (sb.size() > 0) begin
               void'(sb.pop_front());
               check("missing_issue", cmd_valid_out, 1);
            end
            check("idle_grant", grant_out, 0);
         end
         check("credits", credits_out, m_credits);
         check("issued_count", issued_count_out, m_count);
         check("credit_error", credit_error_out, m_err);
         check("src_hold", cmd_src_out, m_src);
         check("tag_hold", cmd_tag_out, m_out_tag);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic start(input int init);
      enabled_in = 1'b0;
      tick();
      enabled_in = 1'b1;
      tick();
      credit_init       = CW'(init);
      credit_init_valid = 1'b1;
      tick();
      credit_init_valid = 1'b0;
   endtask

   initial begin
      bit done;
      tick(2);
      check("rst_grant", grant_out, 0);
      check("rst_valid", cmd_valid_out, 0);
      check("rst_credits", credits_out, 0);
      check("rst_count", issued_count_out, 0);
      rstn = 1'b1;

      // Four credits, everyone requesting: 0,1,2,3 then starve.
      start(4);
      req_valid = 4'b1111;
      tick(8);
      check("req033_credits", credits_out, 0);
      check("req033_count", issued_count_out, 4);

      // One returned credit releases exactly one grant.
      credit_return = 1'b1;
      tick();
      credit_return = 1'b0;
      tick(4);
      check("req034_count", issued_count_out, 5);
      check("req034_credits", credits_out, 0);
      req_valid = '0;

      // Issue and return together leave credits untouched.
      start(2);
      req_valid = 4'b0001;
      tick();
      credit_return = 1'b1;
      req_valid     = '0;
      tick();
      credit_return = 1'b0;
      tick(2);
      check("req035_credits", credits_out, 2);
      check("req035_count", issued_count_out, 1);

      // Return at full credit sets a sticky error.
      start(3);
      credit_return = 1'b1;
      tick();
      credit_return = 1'b0;
      tick(3);
      check("req036_credits", credits_out, 3);
      check("req036_error", credit_error_out, 1);
      enabled_in = 1'b0;
      tick();
      check("req036_error_clr", credit_error_out, 0);

      // Tag wrap over 257 issues.
      start(200);
      req_valid = 4'b1111;
      tick(2);
      credit_return = 1'b1;
      done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         if (m_count >= 256) done = 1;
      end
      if (!done) check("req037_timeout", issued_count_out, 256);
      req_valid     = '0;
      credit_return = 1'b0;
      tick(3);
      check("req037_count", issued_count_out, 257);
      check("req037_tag", cmd_tag_out, 0);

      // Async reset with a captured but ungranted request, then first grant after re-enable.
      start(8);
      req_valid = 4'b0011;
      tick(4);
      req_valid = 4'b0100;
      tick();
      #2 rstn = 1'b0;
      #1;
      check("req038_grant", grant_out, 0);
      check("req038_valid", cmd_valid_out, 0);
      check("req038_src", cmd_src_out, 0);
      check("req038_tag", cmd_tag_out, 0);
      check("req038_credits", credits_out, 0);
      check("req038_count", issued_count_out, 0);
      tick(2);
      rstn = 1'b1;
      req_valid = '0;
      start(4);
      req_valid = 4'b0110;
      tick(2);
      check("req038_first_valid", cmd_valid_out, 1);
      check("req038_first_src", cmd_src_out, 1);
      req_valid = '0;

      // Random traffic; sources mostly drop their request once granted.
      start(3);
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < N; b++) begin
            if (grant_out[b]) begin
               if ($urandom_range(0, 3) != 0) req_valid[b] = 1'b0;
            end else if (!req_valid[b] && $urandom_range(0, 3) == 0) begin
               req_valid[b] = 1'b1;
            end
         end
         credit_return     = ($urandom_range(0, 3) == 0);
         credit_init_valid = ($urandom_range(0, 15) == 0);
         credit_init       = CW'($urandom_range(0, 6));
         enabled_in        = ($urandom_range(0, 199) != 0);
         tick();
      end
      req_valid         = '0;
      credit_return     = 1'b0;
      credit_init_valid = 1'b0;
      tick(4);
      check("sb_drain", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
